// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, transmitter state encoding and bit-timing helper
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  function automatic int symbol_cycles(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock circular FIFO with occupancy count, shared by UART TX and RX
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - 8N1 UART transmitter fed from a byte FIFO, frames sent back-to-back
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [UART_DATA_W-1:0]        data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int SYM   = symbol_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W = (SYM > 1) ? $clog2(SYM) : 1;

  tx_state_t              state;
  tx_state_t              next_state;
  logic [CNT_W-1:0]       baud_cnt;
  logic                   sym_end;
  logic [UART_DATA_W-1:0] shift;
  logic [2:0]             bit_idx;
  logic                   serial_q;
  logic                   serial_next;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] fifo_data;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (data_in_valid),
    .push_data (data_in),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign sym_end       = (baud_cnt == CNT_W'(SYM - 1));
  assign data_in_ready = !fifo_full;
  assign tx_busy       = (state != ST_IDLE) || (fifo_count != '0);
  assign serial_out    = serial_q;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) next_state = ST_START;
      ST_START: if (sym_end) next_state = ST_DATA;
      ST_DATA:  if (sym_end && bit_idx == 3'd7) next_state = ST_STOP;
      ST_STOP:  if (sym_end) next_state = fifo_empty ? ST_IDLE : ST_START;
    endcase
  end

  // Line level is registered, so it trails the state register by one cycle.
  always_comb begin
    pop         = 1'b0;
    serial_next = 1'b1;
    case (state)
      ST_IDLE:  pop = !fifo_empty;
      ST_START: serial_next = 1'b0;
      ST_DATA:  serial_next = shift[0];
      ST_STOP:  pop = sym_end && !fifo_empty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      baud_cnt <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      serial_q <= 1'b1;
    end else begin
      serial_q <= serial_next;
      baud_cnt <= (state == ST_IDLE || sym_end) ? '0 : baud_cnt + 1'b1;
      if (pop) begin
        shift   <= fifo_data;
        bit_idx <= '0;
      end else if (state == ST_DATA && sym_end) begin
        shift   <= {1'b0, shift[UART_DATA_W-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - directed self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

  localparam int CLOCK_FREQ = 50_000_000;
  localparam int BAUD_RATE  = 115_200;
  localparam int FIFO_DEPTH = 8;
  localparam int SYM        = CLOCK_FREQ / BAUD_RATE;
  localparam int FRAME      = 10 * SYM;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;
  logic       tx_busy;
  logic [3:0] fifo_count;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  uart_tx_buffered #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .serial_out    (serial_out),
    .tx_busy       (tx_busy),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("idle_reached", tx_busy, 0);
  endtask

  // Receiver model: find start edge, sample each bit mid-symbol, end mid stop bit.
  task automatic rx(output logic [7:0] b, output int t0);
    int n;
    n = 0;
    b = 8'h00;
    while (serial_out !== 1'b0 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("rx_start_found", serial_out, 0);
    t0 = cyc;
    repeat (SYM / 2) tick();
    chk("rx_start_mid", serial_out, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (SYM) tick();
      b[i] = serial_out;
    end
    repeat (SYM) tick();
    chk("rx_stop_mid", serial_out, 1);
  endtask

  initial begin
    logic [9:0] fbits;
    logic [7:0] b;
    int         t0;
    int         t1;
    logic [7:0] exp_q [4];

    // Reset held low
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_serial", serial_out, 1);
      chk("rst_ready", data_in_ready, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_count", fifo_count, 0);
    end
    rst = 1'b1;
    tick();

    // Single byte A5 with exact bit timing
    data_in = 8'hA5;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    chk("single_count_n", fifo_count, 1);
    chk("single_busy_n", tx_busy, 1);
    chk("single_serial_n", serial_out, 1);
    tick();
    chk("single_count_n1", fifo_count, 0);
    chk("single_serial_n1", serial_out, 1);
    tick();
    fbits = {1'b1, 8'hA5, 1'b0};
    for (int s = 0; s < 10; s++) begin
      chk($sformatf("single_sym%0d_first", s), serial_out, fbits[s]);
      repeat (SYM - 2) tick();
      if (s == 9) chk("single_busy_last", tx_busy, 1);
      tick();
      chk($sformatf("single_sym%0d_last", s), serial_out, fbits[s]);
      if (s == 9) chk("single_busy_fall", tx_busy, 0);
      tick();
    end
    chk("single_idle_serial", serial_out, 1);

    // Burst of three on consecutive cycles
    data_in = 8'h11;
    data_in_valid = 1'b1;
    tick();
    chk("burst_count0", fifo_count, 1);
    data_in = 8'h22;
    tick();
    chk("burst_count1", fifo_count, 1);
    data_in = 8'h33;
    tick();
    data_in_valid = 1'b0;
    chk("burst_count_peak", fifo_count, 2);
    rx(b, t0);
    chk("burst_byte0", b, 8'h11);
    rx(b, t1);
    chk("burst_byte1", b, 8'h22);
    chk("burst_gap01", t1 - t0, FRAME);
    t0 = t1;
    rx(b, t1);
    chk("burst_byte2", b, 8'h33);
    chk("burst_gap12", t1 - t0, FRAME);
    wait_idle();

    // Fill: one byte in flight plus eight queued, tenth push stalls
    data_in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      data_in = 8'h40 + 8'(i);
      tick();
    end
    chk("full_count", fifo_count, 8);
    chk("full_ready", data_in_ready, 0);
    data_in = 8'h49;
    repeat (4332) tick();
    chk("full_stall_ready", data_in_ready, 0);
    chk("full_stall_count", fifo_count, 8);
    tick();
    chk("full_pop_count", fifo_count, 7);
    chk("full_pop_ready", data_in_ready, 1);
    tick();
    data_in_valid = 1'b0;
    chk("full_refill_count", fifo_count, 8);
    chk("full_refill_ready", data_in_ready, 0);
    rst = 1'b0;
    tick();
    chk("flush_serial", serial_out, 1);
    chk("flush_count", fifo_count, 0);
    chk("flush_ready", data_in_ready, 1);
    chk("flush_busy", tx_busy, 0);
    rst = 1'b1;
    tick();

    // Push and pop in the same cycle at a STOP boundary
    data_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'h81 + 8'(i);
      tick();
    end
    data_in_valid = 1'b0;
    chk("pp_count_pre", fifo_count, 3);
    repeat (4337) tick();
    chk("pp_count_before", fifo_count, 3);
    data_in = 8'h85;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    chk("pp_count_same", fifo_count, 3);
    exp_q = '{8'h82, 8'h83, 8'h84, 8'h85};
    t0 = 0;
    for (int i = 0; i < 4; i++) begin
      rx(b, t1);
      chk($sformatf("pp_byte%0d", i), b, exp_q[i]);
      if (i > 0) chk($sformatf("pp_gap%0d", i), t1 - t0, FRAME);
      t0 = t1;
    end
    wait_idle();

    // Reset during DATA bit 4, then a fresh byte
    data_in = 8'hC3;
    data_in_valid = 1'b1;
    tick();
    data_in = 8'h77;
    tick();
    data_in_valid = 1'b0;
    chk("mid_count_pre", fifo_count, 1);
    repeat (5 * SYM + 200) tick();
    chk("mid_bit4", serial_out, 0);
    rst = 1'b0;
    tick();
    chk("mid_rst_serial", serial_out, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", tx_busy, 0);
    rst = 1'b1;
    tick();
    chk("mid_after_serial", serial_out, 1);
    chk("mid_after_busy", tx_busy, 0);
    data_in = 8'h5A;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    rx(b, t0);
    chk("mid_fresh_byte", b, 8'h5A);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Serial 8N1 UART transmitter with a small input FIFO. It drives the `serial_out` line that the CPU exposes to the outside world.
- It is the transmit-side counterpart to the CPU's serial receive path.
- The CPU/MMIO side pushes bytes through a ready/valid handshake. The block serialises them back-to-back at `BAUD_RATE`, so the core does not stall during bursts.

Parameters:
- `CLOCK_FREQ`, 50_000_000, clk frequency in Hz.
- `BAUD_RATE`, 115_200, line rate in bit/s.
- `FIFO_DEPTH`, 8, byte entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous reset, active-low (asserted when 0, sampled on posedge `clk`).
- `data_in`  in  8  byte to transmit.
- `data_in_valid`  in  1  producer has a byte on `data_in`.
- `data_in_ready`  out  1  FIFO can accept a byte this cycle.
- `serial_out`  out  1  UART line; idle high.
- `tx_busy`  out  1  a frame is being shifted out, or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of bytes currently queued.

Behaviour:
- Bit timing:
  - `SYMBOL_CYCLES` = `CLOCK_FREQ`/`BAUD_RATE`, integer division (434 at the defaults).
  - Each bit is held for exactly `SYMBOL_CYCLES` clk cycles.
  - The baud counter is only enabled outside IDLE and restarts at 0 on every bit boundary.
- Reset (`rst`==0 at posedge):
  - `serial_out`=1, `data_in_ready`=1, `tx_busy`=0, `fifo_count`=0.
  - FIFO pointers cleared, FSM forced to IDLE.
  - A frame in flight is abandoned immediately; the line returns high on the next cycle.
- Push handshake:
  - A transfer happens when `data_in_valid`&&`data_in_ready` at posedge.
  - `data_in_ready` = !full, combinational from registered state only (no path from `data_in_valid`).
  - While full, `data_in_ready`=0, even if a pop occurs in the same cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - `serial_out`=1.
    - If FIFO non-empty: pop the head into the 8-bit shift register, clear the bit index, go to START.
  - START: `serial_out`=0 for `SYMBOL_CYCLES`, then go to DATA.
  - DATA:
    - `serial_out`=shift[0], LSB first.
    - On each symbol end, shift right and increment the index.
    - After bit 7 completes, go to STOP.
  - STOP: `serial_out`=1 for `SYMBOL_CYCLES`. Then:
    - FIFO non-empty: pop and go directly to START (no idle gap).
    - FIFO empty: go to IDLE.
- Latency: a byte pushed into an empty FIFO while IDLE at posedge N is popped at N+1, and `serial_out` falls at N+2.
- Frame length: 10×`SYMBOL_CYCLES` cycles.
- `serial_out` is driven from a register (glitch-free).
- FIFO:
  - Circular buffer with pointer width $clog2(`FIFO_DEPTH`) and wrap-around.
  - Full/empty are determined by `fifo_count`.
  - A simultaneous push and pop (not full) leaves the count unchanged.
  - A pop while empty is impossible by construction.
- `tx_busy` = (state!=IDLE) || (`fifo_count`!=0).

Decomposition:
- Shared package `uart_pkg`:
  - `SYMBOL_CYCLES` function.
  - FSM state encoding (2-bit enum).
  - `UART_DATA_W`=8.
- One sub-module, `sync_fifo` (`WIDTH`, `DEPTH`), with push/pop/full/empty/count. It is reusable later for the receive side.
- The FSM, baud counter and shift register live in `uart_tx_buffered`.

Test Plan:
- Reset: hold `rst`=0 for 10 cycles → `serial_out`=1, `data_in_ready`=1, `tx_busy`=0, `fifo_count`=0 throughout.
- Single byte 8'hA5 pushed at cycle N → `serial_out` low from N+2 for 434 cycles, then bits 1,0,1,0,0,1,0,1, each 434 cycles. Stop bit high 434 cycles. `tx_busy` falls after 4340 cycles.
- Burst: push 0x11,0x22,0x33 on consecutive cycles → `fifo_count` peaks at 2. Three frames are sent back-to-back with no idle gap; a receiver model decodes 0x11,0x22,0x33.
- Full: push 9 bytes with `data_in_valid` held high → 1 byte in flight plus 8 queued. `data_in_ready` goes low and the 10th push stalls until the first frame's STOP completes.
- Push and pop in the same cycle (FIFO at count 3 at a STOP boundary) → `fifo_count` stays 3, and the byte order is preserved.
- Reset mid-frame: assert `rst`=0 during DATA bit 4 → the next cycle `serial_out`=1 and `fifo_count`=0. After release, a fresh push of 0x5A transmits correctly.
